// File: rtl/xm_mmio_unit.sv
// X/M stage memory-mapped I/O and store-path controller.
// Produces byte-lane write enables for DMEM/IMEM, owns a one-deep UART
// transmit buffer (stalls the pipe when a second byte arrives too early),
// a bank of performance counters and the registered MMIO load-data path.
//
// TX buffer states:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   TX_EMPTY | no byte buffered; a TX store is accepted immediately
//   TX_FULL  | byte buffered and offered on uart_tx_*; a new TX store
//            | stalls until the current byte is taken
module xm_mmio_unit #(
  parameter int                W_SIZE    = 32,
  parameter int                CNT_W     = 32,
  parameter int                N_CNT     = 4,
  parameter logic [W_SIZE-1:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_xm,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        func3,
  input  logic [W_SIZE-1:0] addr,
  input  logic [W_SIZE-1:0] wdata,
  input  logic              bios_mode,
  input  logic [N_CNT-1:0]  cnt_evt,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [W_SIZE-1:0] mem_wdata,
  output logic              stall,
  output logic              uart_tx_valid,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_tx_ready,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  output logic              uart_rx_ready,
  output logic [W_SIZE-1:0] mmio_rdata
);

  // Word offsets inside the 4 KiB MMIO window.
  localparam logic [9:0] WOFF_STATUS = 10'h000;
  localparam logic [9:0] WOFF_RX     = 10'h001;
  localparam logic [9:0] WOFF_TX     = 10'h002;
  localparam logic [9:0] WOFF_CLR    = 10'h006;
  localparam logic [3:0] WOFF_CNT_HI = 4'h1;     // 0x100 .. 0x1FF
  localparam logic [5:0] N_CNT_W     = 6'(N_CNT);

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_t;

  tx_state_t         tx_state;
  logic [7:0]        tx_buf;
  logic [CNT_W-1:0]  cnt_q [N_CNT];

  logic              store_v;
  logic              load_v;
  logic              mmio_hit;
  logic [9:0]        word_off;
  logic              hit_status;
  logic              hit_rx;
  logic              hit_tx;
  logic              hit_clr;
  logic              hit_cnt;
  logic              tx_wr;
  logic              cnt_clr;
  logic              rd_en;
  logic [3:0]        lane_mask;
  logic              dmem_sel;
  logic              imem_sel;
  logic [W_SIZE-1:0] rd_val;

  // func3[2] only distinguishes signed/unsigned loads, which the W stage
  // handles; cnt_evt[0] is replaced by the free-running cycle count.
  logic unused_bits;
  assign unused_bits = ^{func3[2], cnt_evt[0]};

  assign store_v  = valid_xm & is_store;
  assign load_v   = valid_xm & is_load;
  assign mmio_hit = (addr[W_SIZE-1:12] == MMIO_BASE[W_SIZE-1:12]);
  assign word_off = addr[11:2];

  assign hit_status = mmio_hit & (word_off == WOFF_STATUS);
  assign hit_rx     = mmio_hit & (word_off == WOFF_RX);
  assign hit_tx     = mmio_hit & (word_off == WOFF_TX);
  assign hit_clr    = mmio_hit & (word_off == WOFF_CLR);
  assign hit_cnt    = mmio_hit & (word_off[9:6] == WOFF_CNT_HI)
                               & (word_off[5:0] < N_CNT_W);

  // Only a TX store against a full, non-draining buffer can hold the pipe.
  assign stall = store_v & hit_tx & (tx_state == TX_FULL) & ~uart_tx_ready;

  assign tx_wr   = store_v & hit_tx  & ~stall;
  assign cnt_clr = store_v & hit_clr & ~stall;
  assign rd_en   = load_v  & mmio_hit & ~stall;

  // RX byte is consumed in the same cycle the load reads it.
  assign uart_rx_ready = load_v & hit_rx;

  assign uart_tx_valid = (tx_state == TX_FULL);
  assign uart_tx_data  = tx_buf;

  // Byte-lane mask from access width; misaligned accesses just shift.
  always_comb begin
    lane_mask = 4'b0000;
    case (func3[1:0])
      2'b00:   lane_mask = 4'b0001 << addr[1:0];
      2'b01:   lane_mask = 4'b0011 << {addr[1], 1'b0};
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  assign dmem_sel = (addr[31:30] == 2'b00) & addr[28];
  assign imem_sel = bios_mode & (addr[31:29] == 3'b001);

  assign dmem_we   = (store_v & dmem_sel & ~stall) ? lane_mask : 4'b0000;
  assign imem_we   = (store_v & imem_sel & ~stall) ? lane_mask : 4'b0000;
  assign mem_wdata = wdata << {addr[1:0], 3'b000};

  // Transmit buffer: capture on store, release on handshake, refill in place
  // when a stalled store meets the draining handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_EMPTY;
      tx_buf   <= 8'h00;
    end else begin
      case (tx_state)
        TX_EMPTY: begin
          if (tx_wr) begin
            tx_buf   <= wdata[7:0];
            tx_state <= TX_FULL;
          end
        end
        TX_FULL: begin
          if (uart_tx_ready) begin
            if (tx_wr) begin
              tx_buf <= wdata[7:0];
            end else begin
              tx_state <= TX_EMPTY;
            end
          end
        end
        default: tx_state <= TX_EMPTY;
      endcase
    end
  end

  // Performance counters; software clear takes priority over any increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_CNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CNT; k++) begin
        if (cnt_clr) begin
          cnt_q[k] <= '0;
        end else if ((k == 0) || cnt_evt[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  // MMIO read mux; unmapped offsets and write-only registers read as zero.
  always_comb begin
    rd_val = '0;
    if (hit_status) begin
      rd_val = W_SIZE'({uart_rx_valid, tx_state == TX_EMPTY});
    end else if (hit_rx) begin
      rd_val = W_SIZE'(uart_rx_data);
    end else if (hit_cnt) begin
      for (int k = 0; k < N_CNT; k++) begin
        if (word_off[2:0] == 3'(k)) begin
          rd_val = W_SIZE'(cnt_q[k]);
        end
      end
    end
  end

  // Load data register feeding the W stage; holds between MMIO loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mmio_rdata <= '0;
    end else if (rd_en) begin
      mmio_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_xm_mmio_unit.sv
// Directed bench for xm_mmio_unit: one main instance (N_CNT=4, CNT_W=8)
// plus N_CNT=2 and N_CNT=8 instances sharing the same stimulus.
module tb_xm_mmio_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_xm = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        bios_mode = 1'b0;
  logic [7:0]  cnt_evt = 8'd0;
  logic        uart_tx_ready = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = 8'd0;

  logic [3:0]  dmem_we, imem_we;
  logic [31:0] mem_wdata, mmio_rdata;
  logic        stall, uart_tx_valid, uart_rx_ready;
  logic [7:0]  uart_tx_data;

  logic [3:0]  n2_dmem_we, n2_imem_we, n8_dmem_we, n8_imem_we;
  logic [31:0] n2_mem_wdata, n2_mmio_rdata, n8_mem_wdata, n8_mmio_rdata;
  logic        n2_stall, n2_tx_valid, n2_rx_ready, n8_stall, n8_tx_valid, n8_rx_ready;
  logic [7:0]  n2_tx_data, n8_tx_data;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_CLR    = 32'h8000_0018;

  always #5 clk = ~clk;

  xm_mmio_unit #(.W_SIZE(32), .CNT_W(8), .N_CNT(4), .MMIO_BASE(32'h8000_0000)) u_dut (
    .clk(clk), .rst(rst), .valid_xm(valid_xm), .is_load(is_load), .is_store(is_store),
    .func3(func3), .addr(addr), .wdata(wdata), .bios_mode(bios_mode), .cnt_evt(cnt_evt[3:0]),
    .dmem_we(dmem_we), .imem_we(imem_we), .mem_wdata(mem_wdata), .stall(stall),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
    .mmio_rdata(mmio_rdata)
  );

  xm_mmio_unit #(.W_SIZE(32), .CNT_W(32), .N_CNT(2), .MMIO_BASE(32'h8000_0000)) u_n2 (
    .clk(clk), .rst(rst), .valid_xm(valid_xm), .is_load(is_load), .is_store(is_store),
    .func3(func3), .addr(addr), .wdata(wdata), .bios_mode(bios_mode), .cnt_evt(cnt_evt[1:0]),
    .dmem_we(n2_dmem_we), .imem_we(n2_imem_we), .mem_wdata(n2_mem_wdata), .stall(n2_stall),
    .uart_tx_valid(n2_tx_valid), .uart_tx_data(n2_tx_data), .uart_tx_ready(uart_tx_ready),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(n2_rx_ready),
    .mmio_rdata(n2_mmio_rdata)
  );

  xm_mmio_unit #(.W_SIZE(32), .CNT_W(32), .N_CNT(8), .MMIO_BASE(32'h8000_0000)) u_n8 (
    .clk(clk), .rst(rst), .valid_xm(valid_xm), .is_load(is_load), .is_store(is_store),
    .func3(func3), .addr(addr), .wdata(wdata), .bios_mode(bios_mode), .cnt_evt(cnt_evt),
    .dmem_we(n8_dmem_we), .imem_we(n8_imem_we), .mem_wdata(n8_mem_wdata), .stall(n8_stall),
    .uart_tx_valid(n8_tx_valid), .uart_tx_data(n8_tx_data), .uart_tx_ready(uart_tx_ready),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(n8_rx_ready),
    .mmio_rdata(n8_mmio_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    valid_xm = 1'b0; is_load = 1'b0; is_store = 1'b0;
    func3 = 3'd0; addr = 32'd0; wdata = 32'd0; bios_mode = 1'b0;
  endtask

  task automatic drive_load(input logic [31:0] a);
    valid_xm = 1'b1; is_load = 1'b1; is_store = 1'b0; func3 = 3'd2; addr = a; wdata = 32'd0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    valid_xm = 1'b1; is_load = 1'b0; is_store = 1'b1; func3 = f; addr = a; wdata = d;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      cnt_evt = (i % 2 == 0) ? 8'hFF : 8'h00;
      uart_tx_ready = ~uart_tx_ready;
      uart_rx_valid = ~uart_rx_valid;
      drive_store(A_TX, 32'h99 + 32'(i), 3'd2);
      tick;
      total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b exp=0", uart_tx_valid); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
      total++; if (mmio_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", mmio_rdata); end
      total++; if ({dmem_we, imem_we, uart_rx_ready} !== 9'd0) begin bad++; $display("FAIL rst_we_rxr got=%b exp=0", {dmem_we, imem_we, uart_rx_ready}); end
    end
    idle; cnt_evt = 8'h00; uart_tx_ready = 1'b0; uart_rx_valid = 1'b0;
    rst = 1'b1;
    tick;
    drive_load(A_STATUS);
    #1;
    total++; if (uart_rx_ready !== 1'b0) begin bad++; $display("FAIL status_rxr got=%b exp=0", uart_rx_ready); end
    tick;
    idle;
    total++; if (mmio_rdata !== 32'h1) begin bad++; $display("FAIL reset_status got=%h exp=00000001", mmio_rdata); end
  endtask

  logic        sv_valid [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
  logic [2:0]  sv_f3    [8] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd2, 3'd0, 3'd2};
  logic        sv_bios  [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
  logic [31:0] sv_addr  [8] = '{32'h1000_0003, 32'h2000_0002, 32'h2000_0002, 32'h1000_0010,
                                32'h1000_0001, 32'h0000_0000, 32'h8000_0000, 32'h1000_0000};
  logic [31:0] sv_wdata [8] = '{32'h0000_00AB, 32'h0000_1234, 32'h0000_1234, 32'hDEAD_BEEF,
                                32'h0000_00CD, 32'h1111_2222, 32'h0000_0055, 32'h0000_0001};
  logic [3:0]  sv_dmem  [8] = '{4'b1000, 4'b0000, 4'b0000, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0]  sv_imem  [8] = '{4'b0000, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [31:0] sv_mwd   [8] = '{32'hAB00_0000, 32'h1234_0000, 32'h1234_0000, 32'hDEAD_BEEF,
                                32'h0000_CD00, 32'h1111_2222, 32'h0000_0055, 32'h0000_0001};

  task automatic test_store_lanes;
    for (int i = 0; i < 8; i++) begin
      drive_store(sv_addr[i], sv_wdata[i], sv_f3[i]);
      valid_xm = sv_valid[i];
      bios_mode = sv_bios[i];
      #1;
      total++; if (dmem_we !== sv_dmem[i]) begin bad++; $display("FAIL lane%0d_dmem_we got=%b exp=%b", i, dmem_we, sv_dmem[i]); end
      total++; if (imem_we !== sv_imem[i]) begin bad++; $display("FAIL lane%0d_imem_we got=%b exp=%b", i, imem_we, sv_imem[i]); end
      total++; if (mem_wdata !== sv_mwd[i]) begin bad++; $display("FAIL lane%0d_wdata got=%h exp=%h", i, mem_wdata, sv_mwd[i]); end
      tick;
    end
    idle;
  endtask

  task automatic test_tx_stall;
    int stall_cnt;
    uart_tx_ready = 1'b0;
    drive_store(A_TX, 32'h0000_0041, 3'd2);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL tx_first_stall got=%b exp=0", stall); end
    tick;
    total++; if ({uart_tx_valid, uart_tx_data} !== 9'h141) begin bad++; $display("FAIL tx_first_byte got=%h exp=141", {uart_tx_valid, uart_tx_data}); end
    drive_store(A_TX, 32'h0000_0042, 3'd2);
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (stall === 1'b1) stall_cnt++;
      total++; if (uart_tx_data !== 8'h41) begin bad++; $display("FAIL tx_hold_byte got=%h exp=41", uart_tx_data); end
      tick;
    end
    uart_tx_ready = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL tx_drain_stall got=%b exp=0", stall); end
    tick;
    idle; uart_tx_ready = 1'b0;
    total++; if (stall_cnt !== 5) begin bad++; $display("FAIL tx_stall_cycles got=%0d exp=5", stall_cnt); end
    total++; if ({uart_tx_valid, uart_tx_data} !== 9'h142) begin bad++; $display("FAIL tx_second_byte got=%h exp=142", {uart_tx_valid, uart_tx_data}); end
    drive_load(A_STATUS);
    tick;
    idle;
    total++; if (mmio_rdata !== 32'h0) begin bad++; $display("FAIL tx_full_status got=%h exp=00000000", mmio_rdata); end
    uart_tx_ready = 1'b1;
    tick;
    uart_tx_ready = 1'b0;
    total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL tx_empty_after got=%b exp=0", uart_tx_valid); end
  endtask

  task automatic test_rx;
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
    drive_load(A_RX);
    #1;
    total++; if (uart_rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_pulse got=%b exp=1", uart_rx_ready); end
    tick;
    idle;
    #1;
    total++; if (uart_rx_ready !== 1'b0) begin bad++; $display("FAIL rx_ready_after got=%b exp=0", uart_rx_ready); end
    total++; if (mmio_rdata !== 32'h0000_005A) begin bad++; $display("FAIL rx_data got=%h exp=0000005a", mmio_rdata); end
    drive_load(A_STATUS);
    tick;
    idle; uart_rx_valid = 1'b0;
    total++; if (mmio_rdata !== 32'h3) begin bad++; $display("FAIL rx_status got=%h exp=00000003", mmio_rdata); end
    tick;
    total++; if (mmio_rdata !== 32'h3) begin bad++; $display("FAIL rdata_hold got=%h exp=00000003", mmio_rdata); end
    drive_load(32'h8000_0010);
    tick;
    idle;
    total++; if (mmio_rdata !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=00000000", mmio_rdata); end
  endtask

  task automatic test_mid_reset;
    uart_tx_ready = 1'b0;
    drive_store(A_TX, 32'h0000_0077, 3'd0);
    tick;
    idle;
    total++; if (uart_tx_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b exp=1", uart_tx_valid); end
    #1 rst = 1'b0;
    #1;
    total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_async got=%b exp=0", uart_tx_valid); end
    tick;
    rst = 1'b1;
    tick;
    total++; if (uart_tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_post got=%b exp=0", uart_tx_valid); end
  endtask

  task automatic test_counters;
    drive_store(A_CLR, 32'd0, 3'd2);
    tick;
    idle;
    repeat (300) tick;
    drive_load(32'h8000_0100);
    tick;
    idle;
    total++; if (mmio_rdata !== 32'd44) begin bad++; $display("FAIL cnt0_wrap got=%0d exp=44", mmio_rdata); end
    total++; if (n2_mmio_rdata !== 32'd300) begin bad++; $display("FAIL n2_cnt0 got=%0d exp=300", n2_mmio_rdata); end
    total++; if (n8_mmio_rdata !== 32'd300) begin bad++; $display("FAIL n8_cnt0 got=%0d exp=300", n8_mmio_rdata); end
    cnt_evt = 8'h02;
    repeat (3) tick;
    cnt_evt = 8'h00;
    drive_load(32'h8000_0104);
    tick;
    total++; if (mmio_rdata !== 32'd3) begin bad++; $display("FAIL cnt1_events got=%0d exp=3", mmio_rdata); end
    drive_store(A_CLR, 32'd0, 3'd2);
    cnt_evt = 8'h02;
    tick;
    cnt_evt = 8'h00;
    drive_load(32'h8000_0104);
    tick;
    total++; if (mmio_rdata !== 32'd0) begin bad++; $display("FAIL clr_beats_evt got=%0d exp=0", mmio_rdata); end
    drive_load(32'h8000_0100);
    tick;
    idle;
    total++; if (mmio_rdata !== 32'd1) begin bad++; $display("FAIL cnt0_after_clr got=%0d exp=1", mmio_rdata); end
  endtask

  task automatic test_sweep;
    drive_store(A_CLR, 32'd0, 3'd2);
    tick;
    idle;
    cnt_evt = 8'h8A;
    repeat (5) tick;
    cnt_evt = 8'h80;
    repeat (2) tick;
    cnt_evt = 8'h00;
    drive_load(32'h8000_0104);
    tick;
    total++; if (n2_mmio_rdata !== 32'd5) begin bad++; $display("FAIL n2_cnt1 got=%0d exp=5", n2_mmio_rdata); end
    total++; if (n8_mmio_rdata !== 32'd5) begin bad++; $display("FAIL n8_cnt1 got=%0d exp=5", n8_mmio_rdata); end
    total++; if (mmio_rdata !== 32'd5) begin bad++; $display("FAIL n4_cnt1 got=%0d exp=5", mmio_rdata); end
    drive_load(32'h8000_0108);
    tick;
    total++; if (n2_mmio_rdata !== 32'd0) begin bad++; $display("FAIL n2_cnt_oob got=%0d exp=0", n2_mmio_rdata); end
    drive_load(32'h8000_010C);
    tick;
    total++; if (mmio_rdata !== 32'd5) begin bad++; $display("FAIL n4_cnt3 got=%0d exp=5", mmio_rdata); end
    total++; if (n8_mmio_rdata !== 32'd5) begin bad++; $display("FAIL n8_cnt3 got=%0d exp=5", n8_mmio_rdata); end
    drive_load(32'h8000_0110);
    tick;
    total++; if (mmio_rdata !== 32'd0) begin bad++; $display("FAIL n4_cnt_oob got=%0d exp=0", mmio_rdata); end
    drive_load(32'h8000_011C);
    tick;
    total++; if (n8_mmio_rdata !== 32'd7) begin bad++; $display("FAIL n8_cnt7 got=%0d exp=7", n8_mmio_rdata); end
    drive_load(32'h8000_0120);
    tick;
    idle;
    total++; if (n8_mmio_rdata !== 32'd0) begin bad++; $display("FAIL n8_cnt_oob got=%0d exp=0", n8_mmio_rdata); end
  endtask

  initial begin
    test_reset;
    test_store_lanes;
    test_tx_stall;
    test_rx;
    test_mid_reset;
    test_counters;
    test_sweep;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xm_mmio_unit.md
# xm_mmio_unit

Parametrised memory-mapped I/O and store-path controller for the X/M stage of the three-stage RISC-V core. Generates byte-lane write enables for DMEM/IMEM, owns a one-deep UART transmit buffer with stall, a bank of `N_CNT` performance counters with software reset, and a registered MMIO read-data path that presents load data to the W stage one cycle later.

## Interface
- `W_SIZE`, 32: datapath and address width.
- `CNT_W`, 32: counter width (1..W_SIZE); readback zero-extended.
- `N_CNT`, 4: number of counters (2..8); counter 0 is the cycle counter.
- `MMIO_BASE`, 32'h80000000: base of the MMIO window.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_xm`  in  1  X/M holds a real instruction (not a bubble).
- `is_load`, `is_store`  in  1  decoded opcode class of X/M instruction.
- `func3`  in  3  width field of X/M instruction.
- `addr`  in  W_SIZE  ALU result (effective address).
- `wdata`  in  W_SIZE  rs2 value, unshifted.
- `bios_mode`  in  1  PC_XM[30].
- `cnt_evt`  in  N_CNT  event strobes; bit 0 ignored.
- `dmem_we`, `imem_we`  out  4  byte-lane write enables.
- `mem_wdata`  out  W_SIZE  wdata shifted to lane `addr[1:0]`.
- `stall`  out  1  freeze F/D and X/M this cycle.
- `uart_tx_valid`  out  1, `uart_tx_data` out 8, `uart_tx_ready` in 1.
- `uart_rx_valid`  in  1, `uart_rx_data` in 8, `uart_rx_ready` out 1.
- `mmio_rdata`  out  W_SIZE  registered MMIO load data for W stage.

## Operation
- Address map (offsets from MMIO_BASE): 0x00 status {30'b0, rx_valid, tx_empty}; 0x04 RX data; 0x08 TX data; 0x18 counter reset; 0x100+4k counter k, k < N_CNT. Other MMIO offsets read 0, stores ignored.
- Lane mask: sb → 1<<addr[1:0]; sh → 4'b0011<<{addr[1],1'b0}; sw → 4'b1111; misaligned access: mask as computed, no trap.
- `dmem_we` = mask when store && valid_xm && addr[31:30]==0 && addr[28]; `imem_we` = mask when store && valid_xm && bios_mode && addr[31:29]==3'b001; else 0. Both forced 0 while `stall`.
- TX buffer: states EMPTY/FULL. EMPTY + TX store (valid, not stalled) → capture wdata[7:0], go FULL. FULL drives `uart_tx_valid`=1, `uart_tx_data`=buffer. FULL + `uart_tx_ready` → EMPTY. TX store while FULL and not draining this cycle → `stall`=1; store completes in the cycle `uart_tx_ready` is seen (buffer refilled, stays FULL). Status tx_empty = (state==EMPTY).
- RX: load from 0x04 with valid_xm → `uart_rx_ready`=1 that cycle (combinational), byte captured zero-extended. No stall on empty RX; returns current `uart_rx_data`.
- Counters: counter 0 increments every cycle (incl. stalls); counter k≥1 increments when `cnt_evt[k]`. Wrap modulo 2^CNT_W. Store to 0x18 (valid, not stalled) clears all counters; clear wins over increment in the same cycle.
- `mmio_rdata` register loads selected MMIO value on any valid, non-stalled load to the window; otherwise holds.

## Timing
- Reset (rst low, async): TX buffer EMPTY, all counters 0, `mmio_rdata`=0; hence `uart_tx_valid`=0, `stall`=0, `uart_rx_ready`=0, write enables 0 (inputs low).
- Write enables, `mem_wdata`, `stall`, `uart_rx_ready`: combinational, same cycle as X/M instruction.
- Load latency: MMIO load at cycle t → `mmio_rdata` valid at t+1.
- Counter readback at cycle t returns value before the edge ending t.
- TX: store at t (EMPTY) → `uart_tx_valid` high from t+1 until handshake edge.
- Reset asserted mid-transfer drops the buffered byte; no partial state survives.

## Test plan
- Reset: rst low with all inputs toggling → every output 0, status read after release returns 0x1.
- Store lanes: sb addr 0x10000003 wdata 0xAB → dmem_we 4'b1000, mem_wdata 0xAB000000; sh addr 0x20000002 bios_mode=1 → imem_we 4'b1100; bios_mode=0 → imem_we 0.
- TX stall: two back-to-back TX stores 0x41, 0x42 with uart_tx_ready low for 5 cycles → stall high 5 cycles on second store, 0x41 sent first, 0x42 second, no byte lost.
- RX: uart_rx_valid=1 data 0x5A, load 0x80000004 at t → uart_rx_ready pulse at t, mmio_rdata 0x0000005A at t+1.
- Counters: N_CNT=4, CNT_W=8, run 300 cycles → counter 0 reads 300 mod 256 = 44; store to 0x18 coincident with cnt_evt[1] → counter 1 reads 0 next cycle.
- Parameter sweep N_CNT=2 and 8: read counter N_CNT → 0; highest valid counter counts events correctly.
